// File: rtl/spram_dma.sv
// Fill/copy DMA engine for a single-port RAM: 1 cycle/word fill, 2 cycles/word copy, stalls on hold_i.
// Defining SPRAM_DMA_VERIFY_EN adds a read-back VERIFY/CHECK pass after every write and enables error_o.
module spram_dma #(
    parameter int data_width_g = 8,
    parameter int addr_width_g = 10
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [addr_width_g-1:0]   src_addr_i,
    input  logic [addr_width_g-1:0]   dst_addr_i,
    input  logic [addr_width_g:0]     length_i,
    input  logic [data_width_g-1:0]   fill_data_i,
    input  logic                      hold_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      mem_clken_o,
    output logic                      mem_wren_o,
    output logic [addr_width_g-1:0]   mem_address_o,
    output logic [data_width_g-1:0]   mem_data_o,
    input  logic [data_width_g-1:0]   mem_q_i
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, VERIFY, CHECK, DONE} state_t;

    state_t                    state_q;
    logic                      mode_q;
    logic [addr_width_g-1:0]   src_q, dst_q, addr_q;
    logic [addr_width_g:0]     cnt_q;
    logic [data_width_g-1:0]   fill_q;
    logic [addr_width_g-1:0]   src_d, dst_d;
    logic [addr_width_g:0]     cnt_d;
    logic [data_width_g-1:0]   wr_word;
    logic                      active;
`ifdef SPRAM_DMA_VERIFY_EN
    logic                      error_q;
    logic [data_width_g-1:0]   wdata_q;
`endif

    always_comb begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        wr_word = mode_q ? mem_q_i : fill_q;
        active  = (state_q == READ) || (state_q == WRITE) ||
                  (state_q == VERIFY) || (state_q == CHECK);
    end

    // hold_i gates the RAM port combinationally so the yield takes effect in the same cycle
    assign mem_clken_o   = ((state_q == READ) || (state_q == WRITE) || (state_q == VERIFY)) && !hold_i;
    assign mem_wren_o    = (state_q == WRITE) && !hold_i;
    assign mem_address_o = addr_q;
    assign mem_data_o    = (state_q == WRITE) ? wr_word : fill_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
`ifdef SPRAM_DMA_VERIFY_EN
    assign error_o       = error_q;
`else
    assign error_o       = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
`ifdef SPRAM_DMA_VERIFY_EN
            error_q <= 1'b0;
            wdata_q <= '0;
`endif
        end else if (!(active && hold_i)) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q <= mode_i;
                        src_q  <= src_addr_i;
                        dst_q  <= dst_addr_i;
                        cnt_q  <= length_i;
                        fill_q <= fill_data_i;
`ifdef SPRAM_DMA_VERIFY_EN
                        error_q <= 1'b0;
`endif
                        if (length_i == '0) begin
                            state_q <= DONE;
                        end else if (mode_i) begin
                            state_q <= READ;
                            addr_q  <= src_addr_i;
                        end else begin
                            state_q <= WRITE;
                            addr_q  <= dst_addr_i;
                        end
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    addr_q  <= dst_q;
                end
                WRITE: begin
                    src_q <= src_d;
                    dst_q <= dst_d;
                    cnt_q <= cnt_d;
`ifdef SPRAM_DMA_VERIFY_EN
                    // address stays on the written word for the read-back
                    wdata_q <= wr_word;
                    state_q <= VERIFY;
`else
                    if (cnt_d == '0) begin
                        state_q <= DONE;
                    end else if (mode_q) begin
                        state_q <= READ;
                        addr_q  <= src_d;
                    end else begin
                        state_q <= WRITE;
                        addr_q  <= dst_d;
                    end
`endif
                end
`ifdef SPRAM_DMA_VERIFY_EN
                VERIFY: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (mem_q_i != wdata_q) begin
                        error_q <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else if (mode_q) begin
                        state_q <= READ;
                        addr_q  <= src_q;
                    end else begin
                        state_q <= WRITE;
                        addr_q  <= dst_q;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_dma.sv
// Directed plus randomized bench for spram_dma against a word-level RAM reference model.
module tb_spram_dma;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;
`ifdef SPRAM_DMA_VERIFY_EN
    localparam int PF = 3, PC = 4, CF = 2, CC = 3;
`else
    localparam int PF = 1, PC = 2, CF = 1, CC = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, mode = 1'b0, hold = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic [AW:0] length = '0;
    logic [DW-1:0] fill_data = '0;
    logic busy, done, error, mem_clken, mem_wren;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spram_dma #(.data_width_g(DW), .addr_width_g(AW)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode),
        .src_addr_i(src_addr), .dst_addr_i(dst_addr), .length_i(length),
        .fill_data_i(fill_data), .hold_i(hold), .busy_o(busy), .done_o(done),
        .error_o(error), .mem_clken_o(mem_clken), .mem_wren_o(mem_wren),
        .mem_address_o(mem_address), .mem_data_o(mem_data), .mem_q_i(mem_q)
    );

    // Single-port synchronous RAM; optionally corrupts writes to 0x005
    logic [DW-1:0] ram [DEPTH];
    bit corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_wren) ram[mem_address] <= (corrupt_en && mem_address == 10'h005) ? ~mem_data : mem_data;
            else          mem_q <= ram[mem_address];
        end
    end

    // Port monitor, sampled mid-cycle
    int wr_a[$], wr_d[$], wr_c[$], rd_a[$], ck_c[$], done_c[$];
    int busy_n = 0, held_en = 0, wren_noclk = 0;
    always @(negedge clk) begin
        if (mem_clken) ck_c.push_back(cyc);
        if (mem_clken && mem_wren) begin
            wr_a.push_back(int'(mem_address));
            wr_d.push_back(int'(mem_data));
            wr_c.push_back(cyc);
        end
        if (mem_clken && !mem_wren) rd_a.push_back(int'(mem_address));
        if (mem_wren && !mem_clken) wren_noclk++;
        if (hold && mem_clken) held_en++;
        if (done) done_c.push_back(cyc);
        if (busy) busy_n++;
    end

    // Reference model: memory image and expected write stream
    logic [DW-1:0] refm [DEPTH];
    int exp_a[$], exp_d[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wr_a.delete(); wr_d.delete(); wr_c.delete(); rd_a.delete();
        ck_c.delete(); done_c.delete(); exp_a.delete(); exp_d.delete();
        busy_n = 0;
    endtask

    task automatic model_op(input bit m, input int src, input int dst, input int len, input int fill);
        for (int i = 0; i < len; i++) begin
            int a, d;
            a = (dst + i) % DEPTH;
            d = m ? int'(refm[(src + i) % DEPTH]) : (fill & 8'hFF);
            refm[a] = DW'(d);
            exp_a.push_back(a);
            exp_d.push_back(d);
        end
    endtask

    task automatic issue(input bit m, input int src, input int dst, input int len, input int fill, output int s);
        mode = m; src_addr = AW'(src); dst_addr = AW'(dst);
        length = (AW+1)'(len); fill_data = DW'(fill);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            hold = rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        if (ok) tick(1);
        chk("done_within_budget", 64'(ok), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_write_count"}, 64'(wr_a.size()), 64'(exp_a.size()));
        n = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_write_addr"}, 64'(wr_a[i]), 64'(exp_a[i]));
            chk({tag, "_write_data"}, 64'(wr_d[i]), 64'(exp_d[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, {59'd0, busy, done, error, mem_clken, mem_wren}, 64'd0);
        chk({tag, "_address"}, 64'(mem_address), 64'd0);
        chk({tag, "_data"}, 64'(mem_data), 64'd0);
    endtask

    initial begin
        int s, mm;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = DW'($urandom);
            refm[i] = ram[i];
        end
        ram[10'h3FE] = 8'h11; ram[10'h3FF] = 8'h22; ram[10'h000] = 8'h33; ram[10'h001] = 8'h44;
        refm[10'h3FE] = 8'h11; refm[10'h3FF] = 8'h22; refm[10'h000] = 8'h33; refm[10'h001] = 8'h44;

        #1;
        check_reset_outputs("reset");
        tick(2);
        rst = 1'b0;
        tick(1);

        // Fill 4 words of 0xA5 at 0x100
        clr_log();
        issue(1'b0, 0, 10'h100, 4, 8'hA5, s);
        wait_done(100, 1'b0);
        model_op(1'b0, 0, 10'h100, 4, 8'hA5);
        check_writes("fill4");
        for (int i = 0; i < wr_c.size() && i < 4; i++) chk("fill4_write_cycle", 64'(wr_c[i] - s), 64'(1 + i * PF));
        chk("fill4_done_count", 64'(done_c.size()), 64'd1);
        if (done_c.size() > 0) chk("fill4_done_cycle", 64'(done_c[0] - s), 64'(1 + 4 * PF));
        chk("fill4_busy_cycles", 64'(busy_n), 64'(4 * PF + 1));

        // Copy with wrapping source
        clr_log();
        issue(1'b1, 10'h3FE, 10'h010, 4, 0, s);
        wait_done(100, 1'b0);
        model_op(1'b1, 10'h3FE, 10'h010, 4, 0);
        check_writes("copy4");
        chk("copy4_read_count", 64'(rd_a.size()), 64'(4 * (CC - 1)));
        if (rd_a.size() >= 4 * (CC - 1)) begin
            chk("copy4_read0", 64'(rd_a[0]), 64'h3FE);
            chk("copy4_read1", 64'(rd_a[CC - 1]), 64'h3FF);
            chk("copy4_read2", 64'(rd_a[2 * (CC - 1)]), 64'h000);
            chk("copy4_read3", 64'(rd_a[3 * (CC - 1)]), 64'h001);
        end
        chk("copy4_ram_0x013", 64'(ram[10'h013]), 64'h44);
        if (done_c.size() > 0) chk("copy4_done_cycle", 64'(done_c[0] - s), 64'(1 + 4 * PC));

        // Zero-length copy
        clr_log();
        issue(1'b1, 10'h020, 10'h040, 0, 0, s);
        wait_done(20, 1'b0);
        chk("len0_clken_cycles", 64'(ck_c.size()), 64'd0);
        chk("len0_done_count", 64'(done_c.size()), 64'd1);
        if (done_c.size() > 0) chk("len0_done_cycle", 64'(done_c[0] - s), 64'd1);

        // Hold for 3 cycles between READ and WRITE
        clr_log();
        issue(1'b1, 10'h3FE, 10'h200, 1, 0, s);
        tick(1);
        hold = 1'b1;
        tick(3);
        hold = 1'b0;
        wait_done(50, 1'b0);
        model_op(1'b1, 10'h3FE, 10'h200, 1, 0);
        mm = 0;
        foreach (ck_c[i]) if (ck_c[i] >= s + 2 && ck_c[i] <= s + 4) mm++;
        chk("hold_clken_while_held", 64'(mm), 64'd0);
        check_writes("hold");
        if (wr_c.size() > 0) chk("hold_write_cycle", 64'(wr_c[0] - s), 64'd5);

        // Reset after 2 of 8 fill words
        clr_log();
        issue(1'b0, 0, 10'h300, 8, 8'h3C, s);
        tick(1 + PF);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick(2);
        rst = 1'b0;
        tick(12);
        model_op(1'b0, 0, 10'h300, 2, 8'h3C);
        check_writes("midreset");
        chk("midreset_no_done", 64'(done_c.size()), 64'd0);

`ifdef SPRAM_DMA_VERIFY_EN
        // Read-back mismatch at 0x005 aborts the fill with error set
        clr_log();
        corrupt_en = 1'b1;
        issue(1'b0, 0, 0, 16, 8'h5A, s);
        wait_done(200, 1'b0);
        corrupt_en = 1'b0;
        model_op(1'b0, 0, 0, 6, 8'h5A);
        refm[5] = 8'hA5;
        chk("verify_error", 64'(error), 64'd1);
        chk("verify_write_count", 64'(wr_a.size()), 64'd6);
        if (wr_a.size() > 0) chk("verify_last_write", 64'(wr_a[wr_a.size() - 1]), 64'h005);
        chk("verify_done_count", 64'(done_c.size()), 64'd1);
`endif

        // Randomized fills and copies with random hold
        held_en = 0;
        for (int k = 0; k < 12; k++) begin
            bit m;
            int src, dst, len, fill;
            m = 1'($urandom_range(0, 1));
            src = int'($urandom_range(0, DEPTH - 1));
            dst = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(0, 24));
            fill = int'($urandom_range(0, 255));
            clr_log();
            issue(m, src, dst, len, fill, s);
            wait_done(len * PC * 8 + 40, 1'b1);
            model_op(m, src, dst, len, fill);
            check_writes("rand");
            chk("rand_clken_cycles", 64'(ck_c.size()), 64'(len * (m ? CC : CF)));
            chk("rand_done_count", 64'(done_c.size()), 64'd1);
`ifndef SPRAM_DMA_VERIFY_EN
            chk("rand_error_tied_low", 64'(error), 64'd0);
`endif
        end
        chk("rand_no_clken_under_hold", 64'(held_en), 64'd0);

        // Length beyond the address space rewrites wrapped words
        clr_log();
        issue(1'b0, 0, 10'h3F0, DEPTH + 6, 8'h77, s);
        wait_done((DEPTH + 6) * PF + 40, 1'b0);
        model_op(1'b0, 0, 10'h3F0, DEPTH + 6, 8'h77);
        check_writes("long");

        mm = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== refm[i]) mm++;
        chk("final_ram_image_mismatches", 64'(mm), 64'd0);
        chk("wren_without_clken", 64'(wren_noclk), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spram_dma.md
SPRAM_DMA -- requirements
Module: spram_dma

Interface
REQ-001 SHALL provide parameter data_width_g, default 8, word width of the single-port RAM being driven.
REQ-002 SHALL provide parameter addr_width_g, default 10, address width of the single-port RAM being driven.
REQ-003 SHALL provide clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide start  input  1  command strobe, sampled in IDLE only.
REQ-006 SHALL provide mode  input  1  0 = fill, 1 = copy; latched on accepted start.
REQ-007 SHALL provide src_addr  input  addr_width_g  copy source base; latched on start.
REQ-008 SHALL provide dst_addr  input  addr_width_g  destination base; latched on start.
REQ-009 SHALL provide length  input  addr_width_g+1  word count; latched on start.
REQ-010 SHALL provide fill_data  input  data_width_g  fill value; latched on start.
REQ-011 SHALL provide hold  input  1  bus yield request, e.g. CPU owns RAM.
REQ-012 SHALL provide busy  output  1  high from the cycle after start acceptance until DONE ends.
REQ-013 SHALL provide done  output  1  one-cycle completion pulse.
REQ-014 SHALL provide error  output  1  sticky verify-failure flag.
REQ-015 SHALL provide mem_clken, mem_wren  output  1 each  RAM port enable and write strobe.
REQ-016 SHALL provide mem_address  output  addr_width_g and mem_data  output  data_width_g  RAM address and write data.
REQ-017 SHALL provide mem_q  input  data_width_g  RAM read data, valid one clken-qualified cycle after the read.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, VERIFY, CHECK, DONE.
REQ-019 SHALL, in IDLE with start=1, latch all command inputs, clear error, and go to DONE if length=0, else READ if mode=1, else WRITE.
REQ-020 SHALL ignore start in every state other than IDLE.
REQ-021 SHALL, in READ, drive mem_clken=1, mem_wren=0, mem_address=current source, then go to WRITE.
REQ-022 SHALL, in WRITE, drive mem_clken=1, mem_wren=1, mem_address=current destination, mem_data=mem_q in copy mode or the latched fill value in fill mode.
REQ-023 SHALL, on leaving WRITE, increment source and destination modulo 2^addr_width_g and decrement the remaining count.
REQ-024 SHALL, after WRITE, go to DONE when the remaining count reaches 0, else to READ in copy mode or WRITE in fill mode.
REQ-025 SHALL achieve 1 cycle per word in fill mode and 2 cycles per word in copy mode when hold=0.
REQ-026 SHALL, while hold=1, force mem_clken=0 and mem_wren=0, freeze all state, and resume on the first cycle with hold=0; held mem_q is preserved because the RAM is not enabled.
REQ-027 SHALL accept length values above 2^addr_width_g, with addresses wrapping and words rewritten.
REQ-028 SHALL, in DONE, assert done=1 for exactly one cycle with mem_clken=0, then go to IDLE.
REQ-029 SHALL drive mem_clken=0 and mem_wren=0 in IDLE and DONE.
REQ-030 SHALL keep mem_wren low whenever mem_clken is low.

Reset
REQ-031 SHALL, on reset=1, immediately enter IDLE with busy=0, done=0, error=0, mem_clken=0, mem_wren=0, mem_address=0, mem_data=0, and all counters at 0.
REQ-032 SHALL abandon any in-progress transfer on mid-operation reset, with no further RAM writes and no done pulse.

Configuration
REQ-033 SHALL, when SPRAM_DMA_VERIFY_EN is defined, follow every WRITE with VERIFY (read the same destination address) then CHECK (compare mem_q to the written word).
REQ-034 SHALL, on a CHECK mismatch, set error=1 and go directly to DONE; on a match it SHALL continue as REQ-024 would after WRITE.
REQ-035 SHALL, when SPRAM_DMA_VERIFY_EN is undefined, never enter VERIFY or CHECK and tie error to 0.

Verification
REQ-036 Bench SHALL run fill of dst=0x100, length=4, fill_data=0xA5 -> 4 writes on consecutive cycles to 0x100-0x103, then done pulse; busy high 5 cycles.
REQ-037 Bench SHALL run copy src=0x3FE, dst=0x010, length=4 over RAM preloaded 0x11,0x22,0x33,0x44 -> reads 0x3FE,0x3FF,0x000,0x001 (source wraps) and 0x010-0x013 receive 0x11,0x22,0x33,0x44.
REQ-038 Bench SHALL start a copy with length=0 -> no mem_clken cycles, and done is asserted 1 cycle after start.
REQ-039 Bench SHALL assert hold for 3 cycles between READ and WRITE of a copy -> mem_clken=0 for those 3 cycles and the correct word is written afterward.
REQ-040 Bench SHALL assert reset mid-fill after 2 of 8 words -> exactly 2 words written, outputs at reset values, no done pulse.
REQ-041 Bench SHALL, with SPRAM_DMA_VERIFY_EN defined and a RAM model that corrupts address 0x005, fill 0x000-0x00F with 0x5A -> error=1, last write to 0x005, done pulse.
